// File: rtl/busn2m_pkg.sv
// Shared definitions for the narrow-to-wide bus packer.
//   state_t  : packer FSM encoding (FILL gathers input words, PAD zero-fills
//              the tail of a short final group, DRAIN emits wide words).
//   clog2    : ceiling log2 for sizing helpers.
//   ceil_div : integer ceiling division, used for the output words per blob.
package busn2m_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      PAD   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/busn2m_pack_if.sv
// Handshake bundle between a narrow producer, the packer and a wide consumer.
//   blob_din / blob_din_en / blob_din_eop : narrow word, valid, last-of-blob
//   blob_din_rdy                          : packer can take a narrow word
//   blob_dout / blob_dout_en / blob_dout_eop : wide word, transfer, last-of-blob
//   blob_dout_rdy                         : consumer can take a wide word
// Modports:
//   master : environment side (producer and consumer)
//   slave  : packer side
interface busn2m_pack_if #(
   parameter int IN_WIDTH  = 96,
   parameter int OUT_WIDTH = 512
);

   logic [IN_WIDTH-1:0]  blob_din;
   logic                 blob_din_rdy;
   logic                 blob_din_en;
   logic                 blob_din_eop;
   logic [OUT_WIDTH-1:0] blob_dout;
   logic                 blob_dout_rdy;
   logic                 blob_dout_en;
   logic                 blob_dout_eop;

   modport master (
      output blob_din,
      output blob_din_en,
      output blob_din_eop,
      output blob_dout_rdy,
      input  blob_din_rdy,
      input  blob_dout,
      input  blob_dout_en,
      input  blob_dout_eop
   );

   modport slave (
      input  blob_din,
      input  blob_din_en,
      input  blob_din_eop,
      input  blob_dout_rdy,
      output blob_din_rdy,
      output blob_dout,
      output blob_dout_en,
      output blob_dout_eop
   );

endinterface

// File: rtl/busn2m_pack.sv
// Narrow-to-wide bus packer.
// Gathers IN_WIDTH-bit words into a COM_MUL-bit shift buffer (first word in
// the LSBs) and emits it as OUT_WIDTH-bit words, LSB word first. A blob of N
// input words ends with blob_din_eop; a short final group is zero-padded, and
// output words past the end of the blob (pure padding) are never emitted.
// blob_dout_eop marks the last wide word of each blob.
//
// Ports:
//   clk          : clock
//   rst          : asynchronous active-high reset
//   bus          : busn2m_pack_if.slave handshake bundle (narrow in, wide out)
//   blob_len_err : sticky blob-length error
//
// Build option:
//   BUSN2M_PACK_LEN_CHECK_EN - when defined, blob_len_err flags an eop that
//   arrives on the wrong word count or a blob that runs past N words without
//   eop. When undefined, blob_len_err is constant 0 and no checker exists.
module busn2m_pack
   import busn2m_pkg::*;
#(
   parameter int IN_WIDTH  = 96,
   parameter int OUT_WIDTH = 512,
   parameter int COM_MUL   = 1536,
   parameter int N         = 320
) (
   input  logic           clk,
   input  logic           rst,
   busn2m_pack_if.slave   bus,
   output logic           blob_len_err
);

   localparam int IN_COUNT  = COM_MUL / IN_WIDTH;
   localparam int OUT_COUNT = COM_MUL / OUT_WIDTH;
   localparam int M         = ceil_div(N * IN_WIDTH, OUT_WIDTH);

   localparam logic [15:0] IN_LAST  = 16'(IN_COUNT - 1);
   localparam logic [15:0] OUT_LAST = 16'(OUT_COUNT - 1);
   localparam logic [31:0] M_LAST   = 32'(M - 1);

   state_t               state_r;
   state_t               state_s;
   logic [COM_MUL-1:0]   shift_buf_r;
   logic [COM_MUL-1:0]   shift_buf_s;
   logic [15:0]          din_cnt_r;
   logic [15:0]          din_cnt_s;
   logic [15:0]          dout_cnt_r;
   logic [15:0]          dout_cnt_s;
   logic [31:0]          dout_total_r;
   logic [31:0]          dout_total_s;
   logic                 din_rdy_s;
   logic                 dout_en_s;
   logic                 dout_eop_s;

   // Next-state, buffer and counter update; handshake outputs decode from state.
   always_comb begin
      state_s      = state_r;
      shift_buf_s  = shift_buf_r;
      din_cnt_s    = din_cnt_r;
      dout_cnt_s   = dout_cnt_r;
      dout_total_s = dout_total_r;
      din_rdy_s    = 1'b0;
      dout_en_s    = 1'b0;
      dout_eop_s   = 1'b0;

      case (state_r)
         FILL: begin
            din_rdy_s = 1'b1;
            if (bus.blob_din_en) begin
               shift_buf_s = {bus.blob_din, shift_buf_r[COM_MUL-1:IN_WIDTH]};
               // A full group always drains, even when eop lands on its last
               // slot, so no pad cycles are spent in that case.
               if (din_cnt_r == IN_LAST) begin
                  din_cnt_s = 16'd0;
                  state_s   = DRAIN;
               end else begin
                  din_cnt_s = din_cnt_r + 16'd1;
                  if (bus.blob_din_eop) begin
                     state_s = PAD;
                  end else begin
                     state_s = FILL;
                  end
               end
            end else begin
               state_s = FILL;
            end
         end

         PAD: begin
            // Zero slots push the real words down to the LSBs exactly as
            // real input would; the consumer is not involved here.
            shift_buf_s = {{IN_WIDTH{1'b0}}, shift_buf_r[COM_MUL-1:IN_WIDTH]};
            if (din_cnt_r == IN_LAST) begin
               din_cnt_s = 16'd0;
               state_s   = DRAIN;
            end else begin
               din_cnt_s = din_cnt_r + 16'd1;
               state_s   = PAD;
            end
         end

         DRAIN: begin
            dout_en_s = bus.blob_dout_rdy;
            if (bus.blob_dout_rdy) begin
               shift_buf_s = shift_buf_r >> OUT_WIDTH;
               dout_eop_s  = (dout_total_r == M_LAST);
               if (dout_total_r == M_LAST) begin
                  dout_total_s = 32'd0;
               end else begin
                  dout_total_s = dout_total_r + 32'd1;
               end
               // Leaving on the blob's last word drops any remaining
               // all-pad words of the group.
               if ((dout_cnt_r == OUT_LAST) || (dout_total_r == M_LAST)) begin
                  dout_cnt_s = 16'd0;
                  state_s    = FILL;
               end else begin
                  dout_cnt_s = dout_cnt_r + 16'd1;
                  state_s    = DRAIN;
               end
            end else begin
               state_s = DRAIN;
            end
         end

         default: begin
            state_s      = FILL;
            din_cnt_s    = 16'd0;
            dout_cnt_s   = 16'd0;
            dout_total_s = 32'd0;
         end
      endcase
   end

   // State, shift buffer and counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= FILL;
         shift_buf_r  <= '0;
         din_cnt_r    <= 16'd0;
         dout_cnt_r   <= 16'd0;
         dout_total_r <= 32'd0;
      end else begin
         state_r      <= state_s;
         shift_buf_r  <= shift_buf_s;
         din_cnt_r    <= din_cnt_s;
         dout_cnt_r   <= dout_cnt_s;
         dout_total_r <= dout_total_s;
      end
   end

   assign bus.blob_din_rdy  = din_rdy_s;
   assign bus.blob_dout_en  = dout_en_s;
   assign bus.blob_dout_eop = dout_eop_s;
   assign bus.blob_dout     = shift_buf_r[OUT_WIDTH-1:0];

`ifdef BUSN2M_PACK_LEN_CHECK_EN
   localparam logic [31:0] N_LAST = 32'(N - 1);

   logic        din_xfer_s;
   logic [31:0] din_total_r;
   logic        len_err_r;

   assign din_xfer_s = bus.blob_din_en & din_rdy_s;

   // Accepted-word count within the blob; flags misplaced or missing eop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         din_total_r <= 32'd0;
         len_err_r   <= 1'b0;
      end else if (din_xfer_s) begin
         if (bus.blob_din_eop) begin
            din_total_r <= 32'd0;
            if (din_total_r != N_LAST) begin
               len_err_r <= 1'b1;
            end
         end else if (din_total_r == N_LAST) begin
            din_total_r <= 32'd0;
            len_err_r   <= 1'b1;
         end else begin
            din_total_r <= din_total_r + 32'd1;
         end
      end
   end

   assign blob_len_err = len_err_r;
`else
   assign blob_len_err = 1'b0;
`endif

endmodule

// File: tb/tb_busn2m_pack.sv
// Self-checking bench for busn2m_pack: three instances (N=320, N=20, N=16)
// share one clock/reset and one stimulus driver selected by 'sel'.
`timescale 1ns/1ps
module tb_busn2m_pack;

   localparam int IW = 96;
   localparam int OW = 512;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [IW-1:0] din;
   logic          din_en;
   logic          din_eop;
   logic          dout_rdy;
   logic          hold;
   logic          tog;
   int            sel;
   logic          err320, err20, err16;

   always #5 clk = ~clk;

   busn2m_pack_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) if320 ();
   busn2m_pack_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) if20 ();
   busn2m_pack_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) if16 ();

   assign if320.blob_din      = din;
   assign if320.blob_din_en   = din_en && (sel == 0);
   assign if320.blob_din_eop  = din_eop;
   assign if320.blob_dout_rdy = dout_rdy;
   assign if20.blob_din       = din;
   assign if20.blob_din_en    = din_en && (sel == 1);
   assign if20.blob_din_eop   = din_eop;
   assign if20.blob_dout_rdy  = dout_rdy;
   assign if16.blob_din       = din;
   assign if16.blob_din_en    = din_en && (sel == 2);
   assign if16.blob_din_eop   = din_eop;
   assign if16.blob_dout_rdy  = dout_rdy;

   busn2m_pack #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .COM_MUL(1536), .N(320)) dut320 (
      .clk(clk), .rst(rst), .bus(if320.slave), .blob_len_err(err320));
   busn2m_pack #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .COM_MUL(1536), .N(20)) dut20 (
      .clk(clk), .rst(rst), .bus(if20.slave), .blob_len_err(err20));
   busn2m_pack #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .COM_MUL(1536), .N(16)) dut16 (
      .clk(clk), .rst(rst), .bus(if16.slave), .blob_len_err(err16));

   logic          cur_rdy, cur_en, cur_eop, cur_err;
   logic [OW-1:0] cur_dout;

   always_comb begin
      cur_rdy  = if320.blob_din_rdy;
      cur_en   = if320.blob_dout_en;
      cur_eop  = if320.blob_dout_eop;
      cur_dout = if320.blob_dout;
      cur_err  = err320;
      case (sel)
         1: begin
            cur_rdy = if20.blob_din_rdy; cur_en = if20.blob_dout_en;
            cur_eop = if20.blob_dout_eop; cur_dout = if20.blob_dout; cur_err = err20;
         end
         2: begin
            cur_rdy = if16.blob_din_rdy; cur_en = if16.blob_dout_en;
            cur_eop = if16.blob_dout_eop; cur_dout = if16.blob_dout; cur_err = err16;
         end
         default: ;
      endcase
   end

   // Output capture and rdy/en protocol watch, away from the active edge.
   logic [OW-1:0] outq[$];
   logic          eopq[$];
   int            viol = 0;

   always @(negedge clk) begin
      if (cur_en) begin
         outq.push_back(cur_dout);
         eopq.push_back(cur_eop);
      end
      if ((if320.blob_dout_en || if20.blob_dout_en || if16.blob_dout_en) && !dout_rdy)
         viol++;
   end

   // Consumer ready: held level or toggling every cycle.
   initial begin
      dout_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         dout_rdy = tog ? ~dout_rdy : hold;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic chk_int(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic chk_w(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Word j of the blob bit stream: input k occupies bits 96k..96k+95,
   // value base+k, zero past the n-th word.
   function automatic logic [OW-1:0] model_word(input int base, input int n, input int j);
      logic [OW-1:0] w;
      logic [IW-1:0] v;
      int s;
      int k;
      w = '0;
      for (int b = 0; b < OW; b++) begin
         s = j * OW + b;
         k = s / IW;
         v = (k < n) ? IW'(base + k) : '0;
         w[b] = v[s % IW];
      end
      return w;
   endfunction

   typedef struct {
      int            run;
      int            word;
      int            lo;
      logic [IW-1:0] exp;
   } fld_t;
   fld_t tbl[$];

   task automatic add(input int run, input int word, input int lo, input int exp);
      tbl.push_back('{run, word, lo, IW'(exp)});
   endtask

   task automatic check_fields(input int run);
      logic [OW-1:0] w;
      logic [IW-1:0] f;
      foreach (tbl[i]) begin
         if (tbl[i].run == run) begin
            if (tbl[i].word < outq.size()) begin
               w = outq[tbl[i].word];
               f = w[tbl[i].lo +: IW];
            end else begin
               f = 'x;
            end
            chk_w($sformatf("run%0d word%0d[%0d+:96]", run, tbl[i].word, tbl[i].lo),
                  OW'(f), OW'(tbl[i].exp));
         end
      end
   endtask

   int waits[$];

   task automatic feed(input int which, input int n, input int base, input bit eop_last);
      int w;
      sel = which;
      waits.delete();
      for (int i = 0; i < n; i++) begin
         din     = IW'(base + i);
         din_en  = 1'b1;
         din_eop = eop_last && (i == n - 1);
         w = 0;
         @(negedge clk);
         while (!cur_rdy && w < 200) begin
            w++;
            @(negedge clk);
         end
         if (w >= 200) begin
            chk_int("din_rdy timeout", w, 0);
            break;
         end
         @(posedge clk);
         #1;
         waits.push_back(w);
      end
      din_en  = 1'b0;
      din_eop = 1'b0;
   endtask

   task automatic clear_q();
      outq.delete();
      eopq.delete();
   endtask

   task automatic check_stream(input string name, input int base, input int n,
                               input int m, input int exp_eops);
      int e;
      for (int c = 0; c < 800 && outq.size() < m; c++) @(posedge clk);
      repeat (8) @(posedge clk);
      #1;
      chk_int({name, " out count"}, outq.size(), m);
      for (int j = 0; j < outq.size() && j < m; j++)
         chk_w($sformatf("%s word%0d", name, j), outq[j], model_word(base, n, j));
      e = 0;
      foreach (eopq[i]) e += int'(eopq[i]);
      chk_int({name, " eop count"}, e, exp_eops);
      if (exp_eops > 0 && eopq.size() == m)
         chk_int({name, " eop on last"}, int'(eopq[m-1]), 1);
   endtask

   initial begin
      int bad;
      int p;

      // Hand-computed field expectations: input k sits at stream bit 96k.
      for (int r = 0; r < 2; r++) begin
         add(r, 0, 0, 0);    add(r, 0, 96, 1);    add(r, 0, 384, 4);
         add(r, 3, 0, 16);   add(r, 3, 96, 17);
         add(r, 58, 256, 312); add(r, 59, 416, 319);
      end
      add(2, 0, 96, 1);  add(2, 3, 0, 16);  add(2, 3, 288, 19);
      add(2, 3, 384, 0); add(2, 3, 416, 0);
      add(3, 0, 0, 100); add(3, 3, 288, 119);
      add(4, 0, 96, 1);  add(4, 2, 416, 15);
      add(5, 2, 320, 214); add(5, 2, 416, 0);
      add(6, 0, 0, 1000); add(6, 59, 416, 1319);

      din = '0; din_en = 1'b0; din_eop = 1'b0;
      hold = 1'b1; tog = 1'b0; sel = 0; rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         sel = k;
         #1;
         chk_int($sformatf("reset din_rdy dut%0d", k), int'(cur_rdy), 1);
         chk_int($sformatf("reset dout_en dut%0d", k), int'(cur_en), 0);
         chk_int($sformatf("reset dout_eop dut%0d", k), int'(cur_eop), 0);
         chk_w($sformatf("reset dout dut%0d", k), cur_dout, '0);
         chk_int($sformatf("reset len_err dut%0d", k), int'(cur_err), 0);
      end
      @(posedge clk);
      #1;

      // Full blob, consumer always ready.
      clear_q();
      feed(0, 320, 0, 1'b1);
      bad = 0;
      for (int i = 0; i < waits.size(); i++) begin
         if (i % 16 == 0 && i > 0) chk_int($sformatf("rdy low before word%0d", i), waits[i], 3);
         else bad += (waits[i] != 0) ? 1 : 0;
      end
      chk_int("rdy low elsewhere", bad, 0);
      check_stream("r0", 0, 320, 60, 1);
      check_fields(0);

      // Same blob, consumer ready toggling.
      tog = 1'b1;
      clear_q();
      feed(0, 320, 0, 1'b1);
      check_stream("r1", 0, 320, 60, 1);
      check_fields(1);
      tog = 1'b0;
      chk_int("dout_en while not ready", viol, 0);

      // N=20: second group is 4 words, padded, truncated to one output.
      clear_q();
      feed(1, 20, 0, 1'b1);
      chk_int("n20 rdy low before word16", waits[16], 3);
      p = 0;
      @(negedge clk);
      while (!cur_en && p < 100) begin
         p++;
         @(negedge clk);
      end
      chk_int("n20 pad cycles", p, 12);
      chk_int("n20 eop with final word", int'(cur_eop), 1);
      @(negedge clk);
      chk_int("n20 rdy after eop", int'(cur_rdy), 1);
      check_stream("r2", 0, 20, 4, 1);
      check_fields(2);
      clear_q();
      feed(1, 20, 100, 1'b1);
      check_stream("r3", 100, 20, 4, 1);
      check_fields(3);

      // N=16: eop on the group's last slot, no pad.
      clear_q();
      feed(2, 16, 0, 1'b1);
      p = 0;
      @(negedge clk);
      while (!cur_en && p < 100) begin
         p++;
         @(negedge clk);
      end
      chk_int("n16 pad cycles", p, 0);
      check_stream("r4", 0, 16, 3, 1);
      check_fields(4);

      chk_int("len_err clean", int'(err320 | err20 | err16), 0);

`ifdef BUSN2M_PACK_LEN_CHECK_EN
      // Early eop on word 15 of a 20-word blob.
      clear_q();
      feed(1, 15, 200, 1'b1);
      @(negedge clk);
      chk_int("len_err after short blob", int'(cur_err), 1);
      check_stream("r5", 200, 15, 3, 0);
      check_fields(5);
      chk_int("len_err sticky", int'(cur_err), 1);
`endif

      // Asynchronous reset between output 1 and output 2 of a group.
      clear_q();
      hold = 1'b0;
      feed(0, 16, 500, 1'b0);
      repeat (3) @(posedge clk);
      #1 hold = 1'b1;
      @(posedge clk);
      #1 hold = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk_w("rst dout cleared", cur_dout, '0);
      chk_int("rst din_rdy", int'(cur_rdy), 1);
      chk_int("rst dout_en", int'(cur_en), 0);
      chk_int("rst len_err", int'(err20), 0);
      chk_int("outputs before rst", outq.size(), 1);
      if (outq.size() > 0) chk_w("first output before rst", outq[0], model_word(500, 16, 0));
      @(negedge clk) rst = 1'b0;
      hold = 1'b1;
      clear_q();
      @(posedge clk);
      #1;
      feed(0, 320, 1000, 1'b1);
      check_stream("r6", 1000, 320, 60, 1);
      check_fields(6);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
